// File: rtl/seq_divider_pkg.sv
// Shared constants and types for the sequential divider.
// Contents: FSM state enum, default data width, iteration counter width,
// and the all-ones quotient returned on a zero divisor.
package seq_divider_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned MAX_W  = 64;
  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);

  // Truncated to the operand width at the point of use; every width yields all ones.
  localparam logic [MAX_W-1:0] DBZ_ALL_ONES = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Counter width that can hold the iteration count 0..w.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for the sequential divider.
// Operand side: i_valid/o_ready with i_signed, i_dividend, i_divisor.
// Result side:  o_valid/i_ready with o_quotient, o_remainder, o_div_by_zero.
// slave  = divider view, master = requester/consumer view.
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
);

  logic             i_valid;
  logic             o_ready;
  logic             i_signed;
  logic [WIDTH-1:0] i_dividend;
  logic [WIDTH-1:0] i_divisor;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_quotient;
  logic [WIDTH-1:0] o_remainder;
  logic             o_div_by_zero;

  modport slave (
    input  i_valid, i_signed, i_dividend, i_divisor, i_ready,
    output o_ready, o_valid, o_quotient, o_remainder, o_div_by_zero
  );

  modport master (
    output i_valid, i_signed, i_dividend, i_divisor, i_ready,
    input  o_ready, o_valid, o_quotient, o_remainder, o_div_by_zero
  );

endinterface

// File: rtl/seq_divider_div_restore_step.sv
// One restoring-division iteration (combinational).
// Ports: p            - current partial remainder (WIDTH+1 bits)
//        dividend_bit - next dividend bit, MSB first
//        divisor      - divisor magnitude
//        p_next_c     - partial remainder after the trial subtract/restore
//        q_bit_c      - quotient bit produced by this iteration
module div_restore_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH:0]   p,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   p_next_c,
  output logic             q_bit_c
);

  logic [WIDTH+1:0] shifted_c;
  logic [WIDTH+2:0] diff_c;

  // Extra top bit on the difference gives a clean borrow/sign indicator.
  always_comb begin
    shifted_c = {p, dividend_bit};
    diff_c    = {1'b0, shifted_c} - (WIDTH+3)'(divisor);
    q_bit_c   = ~diff_c[WIDTH+2];
    p_next_c  = q_bit_c ? (WIDTH+1)'(diff_c) : (WIDTH+1)'(shifted_c);
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring integer divider, one quotient bit per cycle.
// Ports: clk - rising-edge clock
//        rst - synchronous active-high reset
//        bus - seq_divider_if.slave operand/result handshake
// Operands are reduced to magnitudes on accept, divided unsigned in CALC,
// and sign-corrected (or replaced by the divide-by-zero result) in FIX.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   p_rem;
  logic [WIDTH-1:0] dvd_sh;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvd_orig;
  logic             neg_q;
  logic             neg_r;
  logic             dbz;

  logic             rdy;
  logic             vld;
  logic [WIDTH-1:0] quo_out;
  logic [WIDTH-1:0] rem_out;
  logic             dbz_out;

  logic             dvd_neg_c;
  logic             dvs_neg_c;
  logic [WIDTH-1:0] dvd_mag_c;
  logic [WIDTH-1:0] dvs_mag_c;
  logic [WIDTH:0]   p_next_c;
  logic             q_bit_c;

  // Operand magnitudes; |-2^(W-1)| wraps to 2^(W-1), which is correct unsigned.
  always_comb begin
    dvd_neg_c = bus.i_signed & bus.i_dividend[WIDTH-1];
    dvs_neg_c = bus.i_signed & bus.i_divisor[WIDTH-1];
    dvd_mag_c = dvd_neg_c ? (~bus.i_dividend + WIDTH'(1)) : bus.i_dividend;
    dvs_mag_c = dvs_neg_c ? (~bus.i_divisor + WIDTH'(1)) : bus.i_divisor;
  end

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .p            (p_rem),
    .dividend_bit (dvd_sh[WIDTH-1]),
    .divisor      (dvs),
    .p_next_c     (p_next_c),
    .q_bit_c      (q_bit_c)
  );

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      p_rem    <= '0;
      dvd_sh   <= '0;
      dvs      <= '0;
      quo      <= '0;
      dvd_orig <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dbz      <= 1'b0;
      rdy      <= 1'b1;
      vld      <= 1'b0;
      quo_out  <= '0;
      rem_out  <= '0;
      dbz_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_valid && rdy) begin
            dvd_sh   <= dvd_mag_c;
            dvs      <= dvs_mag_c;
            dvd_orig <= bus.i_dividend;
            neg_q    <= dvd_neg_c ^ dvs_neg_c;
            neg_r    <= dvd_neg_c;
            dbz      <= (bus.i_divisor == '0);
            p_rem    <= '0;
            quo      <= '0;
            cnt      <= '0;
            rdy      <= 1'b0;
            state    <= (bus.i_divisor == '0) ? FIX : CALC;
          end
        end
        CALC: begin
          p_rem  <= p_next_c;
          quo    <= {quo[WIDTH-2:0], q_bit_c};
          dvd_sh <= {dvd_sh[WIDTH-2:0], 1'b0};
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          // Truncating division: remainder follows the dividend's sign.
          if (dbz) begin
            quo_out <= WIDTH'(DBZ_ALL_ONES);
            rem_out <= dvd_orig;
            dbz_out <= 1'b1;
          end else begin
            quo_out <= neg_q ? (~quo + WIDTH'(1)) : quo;
            rem_out <= neg_r ? (~WIDTH'(p_rem) + WIDTH'(1)) : WIDTH'(p_rem);
            dbz_out <= 1'b0;
          end
          vld   <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (bus.i_ready) begin
            vld   <= 1'b0;
            rdy   <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          rdy   <= 1'b1;
          vld   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ready       = rdy;
  assign bus.o_valid       = vld;
  assign bus.o_quotient    = quo_out;
  assign bus.o_remainder   = rem_out;
  assign bus.o_div_by_zero = dbz_out;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table through a scoreboard,
// plus hand-written backpressure and mid-calculation reset sequences.
module tb_seq_divider;
  import seq_divider_pkg::*;

  localparam int unsigned W = 16;

  typedef struct {
    logic         sgn;
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
    int           start;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[14];

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Monitor: samples mid-low-phase, after the driver has settled its inputs.
  logic prev_vld  = 1'b0;
  logic prev_xfer = 1'b0;
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (prev_xfer) begin
      chk("valid_drop_after_xfer", 32'(bus.o_valid), 32'(0));
      chk("ready_after_xfer", 32'(bus.o_ready), 32'(1));
    end
    if (bus.o_valid && !prev_vld) begin
      if (sb.size() == 0) timeout_fail("unexpected_valid");
      else chk("latency", 32'(cyc - sb[0].start), 32'(sb[0].lat));
    end
    prev_xfer = bus.o_valid && bus.i_ready;
    if (prev_xfer) begin
      if (sb.size() == 0) begin
        timeout_fail("unexpected_result");
      end else begin
        e = sb.pop_front();
        chk("quotient", 32'(bus.o_quotient), 32'(e.q));
        chk("remainder", 32'(bus.o_remainder), 32'(e.r));
        chk("div_by_zero", 32'(bus.o_div_by_zero), 32'(e.dbz));
      end
    end
    prev_vld = bus.o_valid;
  end

  task automatic drive(input logic sgn, input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    bus.i_valid    = 1'b1;
    bus.i_signed   = sgn;
    bus.i_dividend = dvd;
    bus.i_divisor  = dvs;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_ready) begin
      timeout_fail("accept_wait");
      return;
    end
    drive(v.sgn, v.dvd, v.dvs);
    sb.push_back('{v.q, v.r, v.dbz, v.lat, cyc});
    @(negedge clk);
    bus.i_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      timeout_fail("result_wait");
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hi;
    vecs[0]  = '{1'b0, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 18};
    vecs[1]  = '{1'b1, 16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0, 18};
    vecs[2]  = '{1'b1, 16'd100,  16'hFFF9, 16'hFFF2, 16'd2,    1'b0, 18};
    vecs[3]  = '{1'b0, 16'd1234, 16'd0,    16'hFFFF, 16'd1234, 1'b1, 2};
    vecs[4]  = '{1'b1, 16'd1234, 16'd0,    16'hFFFF, 16'd1234, 1'b1, 2};
    vecs[5]  = '{1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 18};
    vecs[6]  = '{1'b0, 16'hFFFF, 16'd1,    16'hFFFF, 16'h0000, 1'b0, 18};
    vecs[7]  = '{1'b1, 16'hFF9C, 16'hFFF9, 16'd14,   16'hFFFE, 1'b0, 18};
    vecs[8]  = '{1'b0, 16'hFFFF, 16'h00FF, 16'd257,  16'd0,    1'b0, 18};
    vecs[9]  = '{1'b1, 16'h8000, 16'd1,    16'h8000, 16'd0,    1'b0, 18};
    vecs[10] = '{1'b0, 16'h8000, 16'hFFFF, 16'd0,    16'h8000, 1'b0, 18};
    vecs[11] = '{1'b1, 16'hFB2E, 16'd0,    16'hFFFF, 16'hFB2E, 1'b1, 2};
    vecs[12] = '{1'b0, 16'd0,    16'd5,    16'd0,    16'd0,    1'b0, 18};
    vecs[13] = '{1'b1, 16'd7,    16'd100,  16'd0,    16'd7,    1'b0, 18};

    bus.i_valid    = 1'b0;
    bus.i_signed   = 1'b0;
    bus.i_dividend = '0;
    bus.i_divisor  = '0;
    bus.i_ready    = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.o_ready), 32'(1));
    chk("rst_valid", 32'(bus.o_valid), 32'(0));
    chk("rst_quotient", 32'(bus.o_quotient), 32'(0));
    chk("rst_remainder", 32'(bus.o_remainder), 32'(0));
    chk("rst_dbz", 32'(bus.o_div_by_zero), 32'(0));
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: 5 cycles of i_ready=0 in DONE with a competing request.
    @(negedge clk);
    bus.i_ready = 1'b0;
    chk("bp_ready_idle", 32'(bus.o_ready), 32'(1));
    drive(1'b0, 16'd50000, 16'd3);
    sb.push_back('{16'd16666, 16'd2, 1'b0, 18, cyc});
    @(negedge clk);
    bus.i_valid = 1'b0;
    n = 0;
    while (!bus.o_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_valid) timeout_fail("bp_valid_wait");
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid_hold", 32'(bus.o_valid), 32'(1));
      chk("bp_ready_low", 32'(bus.o_ready), 32'(0));
      chk("bp_quotient_hold", 32'(bus.o_quotient), 32'(16666));
      chk("bp_remainder_hold", 32'(bus.o_remainder), 32'(2));
      drive(1'b0, 16'd9, 16'd3);
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_after", 32'(bus.o_valid), 32'(0));
    chk("bp_ready_after", 32'(bus.o_ready), 32'(1));
    chk("bp_sb_empty", 32'(sb.size()), 32'(0));
    hi = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.o_valid) hi++;
    end
    chk("bp_ignored_request", 32'(hi), 32'(0));

    // Reset during the 8th CALC cycle discards the operation.
    @(negedge clk);
    drive(1'b0, 16'd60000, 16'd7);
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", 32'(bus.o_valid), 32'(0));
    chk("mid_rst_ready", 32'(bus.o_ready), 32'(1));
    chk("mid_rst_quotient", 32'(bus.o_quotient), 32'(0));
    chk("mid_rst_remainder", 32'(bus.o_remainder), 32'(0));
    chk("mid_rst_dbz", 32'(bus.o_div_by_zero), 32'(0));
    hi = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.o_valid) hi++;
    end
    chk("mid_rst_no_result", 32'(hi), 32'(0));
    run_vec('{1'b0, 16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 18});

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
